pe_stream_ctrl: RTL and testbench



---
 rtl/pe_stream_ctrl_if.sv | 49 ++++
 rtl/pe_stream_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_pe_stream_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_stream_ctrl_if.sv
// -----------------------------------------------------------------------------
// pe_stream_ctrl_if
// Purpose : bundles the job, buffer-read and psum-write signals of one
//           processing-element pass controller into a single port.
// Signals :
//   start, len, clear, abort     job request / length / overwrite mode / cancel
//   mulvalid, offsetaddrpsumin   multiplier result valid, psum base address
//   raddr_inbuf, raddr_index     input / index buffer read addresses
//   rden, inready, krnready      read strobe and delayed read-data-valid
//   rdfifo, offsetaddrpsumout    first-result pulse, captured base address
//   waddr_psum, psum_clr         psum write address, latched overwrite flag
//   outready, busy, done         psum write strobe, job active, completion pulse
// Modports: master = scheduler/datapath side, slave = controller side.
// -----------------------------------------------------------------------------
interface pe_stream_ctrl_if #(
    parameter int ADDRW  = 6,
    parameter int PSUMAW = 12
) ();
    logic              start;
    logic [ADDRW:0]    len;
    logic              clear;
    logic              abort;
    logic              mulvalid;
    logic [PSUMAW-1:0] offsetaddrpsumin;
    logic [ADDRW-1:0]  raddr_inbuf;
    logic [ADDRW-1:0]  raddr_index;
    logic              rden;
    logic              inready;
    logic              krnready;
    logic              rdfifo;
    logic [PSUMAW-1:0] offsetaddrpsumout;
    logic [PSUMAW-1:0] waddr_psum;
    logic              psum_clr;
    logic              outready;
    logic              busy;
    logic              done;

    modport master (
        output start, len, clear, abort, mulvalid, offsetaddrpsumin,
        input  raddr_inbuf, raddr_index, rden, inready, krnready, rdfifo,
               offsetaddrpsumout, waddr_psum, psum_clr, outready, busy, done
    );

    modport slave (
        input  start, len, clear, abort, mulvalid, offsetaddrpsumin,
        output raddr_inbuf, raddr_index, rden, inready, krnready, rdfifo,
               offsetaddrpsumout, waddr_psum, psum_clr, outready, busy, done
    );
endinterface

// File: rtl/pe_stream_ctrl.sv
// -----------------------------------------------------------------------------
// pe_stream_ctrl
// Purpose : sequences one processing-element pass. Streams a runtime length of
//           input/index buffer reads, tracks multiplier results and drives the
//           psum write stream with an auto-incrementing address.
// Ports   :
//   clk     clock
//   rstn    asynchronous active-low reset
//   io_bus  pe_stream_ctrl_if.slave (job, read side, write side signals)
// Parameters: ADDRW buffer address width, PSUMAW psum address width,
//             RDLAT buffer read latency in cycles (1..8).
// -----------------------------------------------------------------------------
module pe_stream_ctrl #(
    parameter int ADDRW  = 6,
    parameter int PSUMAW = 12,
    parameter int RDLAT  = 2
) (
    input  logic             clk,
    input  logic             rstn,
    pe_stream_ctrl_if.slave  io_bus
);

    typedef enum logic [1:0] {IDLE, PREFETCH, RUN, FLUSH} state_t;

    localparam logic [ADDRW:0]    MAXLEN  = {1'b1, {ADDRW{1'b0}}};
    localparam logic [ADDRW:0]    LEN_ONE = (ADDRW+1)'(1);
    localparam logic [ADDRW+1:0]  TWO     = (ADDRW+2)'(2);

    state_t            r_state;
    state_t            w_nextState;

    logic [ADDRW:0]    r_len;
    logic [ADDRW:0]    r_rdCnt;
    logic [ADDRW:0]    r_wrCnt;
    logic              r_first;
    logic              r_rden;
    logic              r_rdfifo;
    logic              r_outready;
    logic              r_busy;
    logic              r_done;
    logic              r_psumClr;
    logic [ADDRW-1:0]  r_raddrInbuf;
    logic [ADDRW-1:0]  r_raddrIndex;
    logic [PSUMAW-1:0] r_offsetOut;
    logic [PSUMAW-1:0] r_waddrPsum;
    logic [RDLAT-1:0]  r_rdPipe;

    logic [ADDRW:0]    w_lenClamp;
    logic [ADDRW:0]    w_lenM1;
    logic              w_lastRead;
    logic              w_lastWrite;
    logic [ADDRW+1:0]  w_idxAhead;
    logic [ADDRW-1:0]  w_idxNext;

    // Job length clamp, last-element detection for both streams, and the
    // index-buffer address that runs one element ahead but never past len-1.
    always_comb begin
        w_lenClamp  = (io_bus.len > MAXLEN) ? MAXLEN : io_bus.len;
        w_lenM1     = r_len - LEN_ONE;
        w_lastRead  = (r_rdCnt == w_lenM1);
        w_lastWrite = io_bus.mulvalid && (r_state != IDLE) && (r_wrCnt == w_lenM1);
        w_idxAhead  = {1'b0, r_rdCnt} + TWO;
        w_idxNext   = (w_idxAhead > {1'b0, w_lenM1}) ? w_lenM1[ADDRW-1:0]
                                                     : w_idxAhead[ADDRW-1:0];
    end

    // Next-state logic. The write side can finish the job from any active
    // state, and abort overrides everything.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:     if (io_bus.start && (io_bus.len != '0)) w_nextState = PREFETCH;
            PREFETCH: w_nextState = RUN;
            RUN:      if (w_lastRead) w_nextState = FLUSH;
            FLUSH:    w_nextState = FLUSH;
            default:  w_nextState = IDLE;
        endcase
        if (w_lastWrite) w_nextState = IDLE;
        if (io_bus.abort) w_nextState = IDLE;
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= IDLE;
        else       r_state <= w_nextState;
    end

    // Registered outputs and counters. The read side and the write side run
    // independently once a job is active; the write side is evaluated last so
    // that a completing write also shuts off any read still in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_len        <= '0;
            r_rdCnt      <= '0;
            r_wrCnt      <= '0;
            r_first      <= 1'b0;
            r_rden       <= 1'b0;
            r_rdfifo     <= 1'b0;
            r_outready   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_psumClr    <= 1'b0;
            r_raddrInbuf <= '0;
            r_raddrIndex <= '0;
            r_offsetOut  <= '0;
            r_waddrPsum  <= '0;
            r_rdPipe     <= '0;
        end else if (io_bus.abort) begin
            r_rden     <= 1'b0;
            r_outready <= 1'b0;
            r_rdfifo   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rdPipe   <= '0;
        end else begin
            r_rdPipe <= RDLAT'({r_rdPipe, r_rden});
            r_done   <= 1'b0;
            if (r_state == IDLE) begin
                r_rden       <= 1'b0;
                r_outready   <= 1'b0;
                r_rdfifo     <= 1'b0;
                r_psumClr    <= 1'b0;
                r_raddrInbuf <= '0;
                r_raddrIndex <= '0;
                r_waddrPsum  <= '0;
                if (io_bus.start) begin
                    if (io_bus.len == '0) begin
                        r_done <= 1'b1;
                    end else begin
                        r_busy    <= 1'b1;
                        r_len     <= w_lenClamp;
                        r_psumClr <= io_bus.clear;
                        r_rdCnt   <= '0;
                        r_wrCnt   <= '0;
                        r_first   <= 1'b1;
                    end
                end
            end else begin
                case (r_state)
                    PREFETCH: begin
                        r_rden       <= 1'b1;
                        r_rdCnt      <= '0;
                        r_raddrInbuf <= '0;
                        r_raddrIndex <= ADDRW'(r_len != LEN_ONE);
                    end
                    RUN: begin
                        if (w_lastRead) begin
                            r_rden <= 1'b0;
                        end else begin
                            r_rdCnt      <= r_rdCnt + LEN_ONE;
                            r_raddrInbuf <= r_raddrInbuf + ADDRW'(1);
                            r_raddrIndex <= w_idxNext;
                        end
                    end
                    default: r_rden <= 1'b0;
                endcase

                if (io_bus.mulvalid) begin
                    r_outready <= 1'b1;
                    r_wrCnt    <= r_wrCnt + LEN_ONE;
                    if (r_first) begin
                        r_rdfifo    <= 1'b1;
                        r_offsetOut <= io_bus.offsetaddrpsumin;
                        r_waddrPsum <= io_bus.offsetaddrpsumin;
                        r_first     <= 1'b0;
                    end else begin
                        r_rdfifo    <= 1'b0;
                        r_waddrPsum <= r_waddrPsum + PSUMAW'(1);
                    end
                    if (w_lastWrite) begin
                        r_done <= 1'b1;
                        r_busy <= 1'b0;
                        r_rden <= 1'b0;
                    end
                end else begin
                    r_outready <= 1'b0;
                    r_rdfifo   <= 1'b0;
                end
            end
        end
    end

    assign io_bus.raddr_inbuf       = r_raddrInbuf;
    assign io_bus.raddr_index       = r_raddrIndex;
    assign io_bus.rden              = r_rden;
    assign io_bus.inready           = r_rdPipe[RDLAT-1];
    assign io_bus.krnready          = r_rdPipe[RDLAT-1];
    assign io_bus.rdfifo            = r_rdfifo;
    assign io_bus.offsetaddrpsumout = r_offsetOut;
    assign io_bus.waddr_psum        = r_waddrPsum;
    assign io_bus.psum_clr          = r_psumClr;
    assign io_bus.outready          = r_outready;
    assign io_bus.busy              = r_busy;
    assign io_bus.done              = r_done;

endmodule

// File: tb/tb_pe_stream_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pe_stream_ctrl
// Purpose : directed, self-checking bench for pe_stream_ctrl (ADDRW=6,
//           PSUMAW=12, RDLAT=2). Inputs change on the falling edge and
//           outputs are compared on the falling edge, away from the active
//           rising edge.
// -----------------------------------------------------------------------------
module tb_pe_stream_ctrl;

    localparam int ADDRW  = 6;
    localparam int PSUMAW = 12;
    localparam int RDLAT  = 2;

    logic clk;
    logic rstn;
    int   checks;
    int   errors;

    pe_stream_ctrl_if #(.ADDRW(ADDRW), .PSUMAW(PSUMAW)) bus ();

    pe_stream_ctrl #(.ADDRW(ADDRW), .PSUMAW(PSUMAW), .RDLAT(RDLAT)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .io_bus (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Runs one complete job from the current falling edge. Cycle c counts
    // falling edges after the start edge: reads occupy c = 2 .. 1+L, read data
    // valid follows RDLAT cycles later, mulvalid is driven at mvStart with a
    // stride of mvStep, and done shows one cycle after the last mulvalid.
    // glitch pulses a zero-length start while the job is busy.
    task automatic applyStimulus(input int lenIn, input bit clr, input logic [11:0] off,
                                 input int mvStart, input int mvStep, input bit glitch);
        int          L;
        int          doneC;
        int          lastIdx;
        bit          prevMv;
        bit          mv;
        logic [11:0] expWaddr;
        L       = (lenIn > 64) ? 64 : lenIn;
        doneC   = mvStart + (L - 1) * mvStep + 1;
        prevMv  = 1'b0;
        lastIdx = 0;
        bus.start            = 1'b1;
        bus.len              = 7'(lenIn);
        bus.clear            = clr;
        bus.offsetaddrpsumin = off;
        for (int c = 1; c <= doneC + 1; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            checkOutput($sformatf("rden c%0d", c), bus.rden, (c >= 2 && c < 2 + L));
            if (c >= 2 && c < 2 + L) begin
                checkOutput($sformatf("raddr_inbuf c%0d", c), bus.raddr_inbuf, c - 2);
                checkOutput($sformatf("raddr_index c%0d", c), bus.raddr_index,
                            (c - 1 < L - 1) ? c - 1 : L - 1);
            end else if (c >= 2 + L && c < doneC) begin
                checkOutput($sformatf("inbuf hold c%0d", c), bus.raddr_inbuf, L - 1);
                checkOutput($sformatf("index hold c%0d", c), bus.raddr_index, L - 1);
            end else if (c == doneC + 1) begin
                checkOutput("inbuf idle", bus.raddr_inbuf, 0);
                checkOutput("waddr idle", bus.waddr_psum, 0);
                checkOutput("psum_clr idle", bus.psum_clr, 0);
            end
            checkOutput($sformatf("inready c%0d", c), bus.inready,
                        (c >= 2 + RDLAT && c < 2 + RDLAT + L));
            checkOutput($sformatf("krnready c%0d", c), bus.krnready,
                        (c >= 2 + RDLAT && c < 2 + RDLAT + L));
            checkOutput($sformatf("outready c%0d", c), bus.outready, prevMv);
            checkOutput($sformatf("rdfifo c%0d", c), bus.rdfifo, (prevMv && lastIdx == 0));
            if (prevMv) begin
                expWaddr = off + 12'(lastIdx);
                checkOutput($sformatf("waddr c%0d", c), bus.waddr_psum, expWaddr);
                checkOutput($sformatf("offset c%0d", c), bus.offsetaddrpsumout, off);
            end
            checkOutput($sformatf("busy c%0d", c), bus.busy, (c < doneC));
            checkOutput($sformatf("done c%0d", c), bus.done, (c == doneC));
            if (c < doneC)
                checkOutput($sformatf("psum_clr c%0d", c), bus.psum_clr, clr);
            mv = (c >= mvStart) && ((c - mvStart) % mvStep == 0) && ((c - mvStart) / mvStep < L);
            bus.mulvalid = mv;
            if (mv) lastIdx = (c - mvStart) / mvStep;
            prevMv = mv;
            if (glitch && c == 3) begin
                bus.start = 1'b1;
                bus.len   = '0;
            end
        end
        bus.mulvalid = 1'b0;
    endtask

    initial begin
        checks               = 0;
        errors               = 0;
        rstn                 = 1'b0;
        bus.start            = 1'b0;
        bus.len              = '0;
        bus.clear            = 1'b0;
        bus.abort            = 1'b0;
        bus.mulvalid         = 1'b0;
        bus.offsetaddrpsumin = '0;

        // Reset state
        @(negedge clk);
        checkOutput("rst busy", bus.busy, 0);
        checkOutput("rst done", bus.done, 0);
        checkOutput("rst rden", bus.rden, 0);
        checkOutput("rst outready", bus.outready, 0);
        checkOutput("rst inready", bus.inready, 0);
        checkOutput("rst waddr", bus.waddr_psum, 0);
        checkOutput("rst psum_clr", bus.psum_clr, 0);
        rstn = 1'b1;
        @(negedge clk);

        // Full 16-element pass, overwrite mode, base 0x100
        applyStimulus(16, 1'b1, 12'h100, 7, 1, 1'b0);

        // Single-element pass
        applyStimulus(1, 1'b0, 12'h055, 5, 1, 1'b0);

        // Zero-length request: done only, no reads, never busy
        bus.start = 1'b1;
        bus.len   = '0;
        @(negedge clk);
        bus.start = 1'b0;
        checkOutput("len0 done", bus.done, 1);
        checkOutput("len0 busy", bus.busy, 0);
        checkOutput("len0 rden", bus.rden, 0);
        @(negedge clk);
        checkOutput("len0 done drop", bus.done, 0);
        checkOutput("len0 busy2", bus.busy, 0);
        checkOutput("len0 rden2", bus.rden, 0);
        checkOutput("len0 outready", bus.outready, 0);

        // mulvalid while idle is ignored
        bus.mulvalid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput($sformatf("idle mv outready %0d", i), bus.outready, 0);
            checkOutput($sformatf("idle mv rdfifo %0d", i), bus.rdfifo, 0);
            checkOutput($sformatf("idle mv busy %0d", i), bus.busy, 0);
        end
        bus.mulvalid = 1'b0;
        @(negedge clk);

        // Job with a zero-length start glitch while busy; counts must be clean
        applyStimulus(5, 1'b0, 12'h3A0, 6, 1, 1'b1);

        // Gapped results with psum address wrap 4094, 4095, 0 .. 5
        applyStimulus(8, 1'b0, 12'd4094, 7, 2, 1'b0);

        // Abort during RUN k=5
        bus.start            = 1'b1;
        bus.len              = 7'd16;
        bus.clear            = 1'b1;
        bus.offsetaddrpsumin = 12'h300;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (c == 7) begin
                checkOutput("abt pre rden", bus.rden, 1);
                checkOutput("abt pre inbuf", bus.raddr_inbuf, 5);
                checkOutput("abt pre outready", bus.outready, 1);
                checkOutput("abt pre waddr", bus.waddr_psum, 12'h301);
                checkOutput("abt pre inready", bus.inready, 1);
            end
            if (c == 8) begin
                checkOutput("abt rden", bus.rden, 0);
                checkOutput("abt outready", bus.outready, 0);
                checkOutput("abt rdfifo", bus.rdfifo, 0);
                checkOutput("abt busy", bus.busy, 0);
                checkOutput("abt done", bus.done, 0);
                checkOutput("abt inready", bus.inready, 0);
                checkOutput("abt krnready", bus.krnready, 0);
            end
            if (c == 9) begin
                checkOutput("abt done2", bus.done, 0);
                checkOutput("abt inbuf idle", bus.raddr_inbuf, 0);
                checkOutput("abt outready2", bus.outready, 0);
            end
            bus.mulvalid = (c >= 5 && c <= 7);
            bus.abort    = (c == 7);
        end
        bus.mulvalid = 1'b0;
        bus.abort    = 1'b0;

        // Normal job after abort starts cleanly from address 0
        applyStimulus(4, 1'b1, 12'h010, 6, 1, 1'b0);

        // Over-length request clamps to 64 elements
        applyStimulus(100, 1'b1, 12'h200, 70, 1, 1'b0);

        // Asynchronous reset in the middle of a job
        bus.start            = 1'b1;
        bus.len              = 7'd4;
        bus.clear            = 1'b1;
        bus.offsetaddrpsumin = 12'h020;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            bus.start    = 1'b0;
            bus.mulvalid = (c == 2 || c == 3);
        end
        checkOutput("mid busy", bus.busy, 1);
        checkOutput("mid outready", bus.outready, 1);
        checkOutput("mid psum_clr", bus.psum_clr, 1);
        #2;
        rstn = 1'b0;
        #1;
        checkOutput("arst busy", bus.busy, 0);
        checkOutput("arst rden", bus.rden, 0);
        checkOutput("arst outready", bus.outready, 0);
        checkOutput("arst psum_clr", bus.psum_clr, 0);
        checkOutput("arst inbuf", bus.raddr_inbuf, 0);
        checkOutput("arst waddr", bus.waddr_psum, 0);
        checkOutput("arst inready", bus.inready, 0);
        checkOutput("arst offset", bus.offsetaddrpsumout, 0);
        @(negedge clk);
        bus.mulvalid = 1'b0;
        rstn         = 1'b1;
        @(negedge clk);
        checkOutput("post rst busy", bus.busy, 0);
        checkOutput("post rst done", bus.done, 0);

        // Recovery job after reset
        applyStimulus(3, 1'b0, 12'h7FF, 6, 1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
